mips_bus_arbiter: RTL
=====================

MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 Parameter: WAIT_LIMIT, default 255, max consecutive waitrequest cycles before abort; 0 disables watchdog.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  instruction-fetch request, held high until if_ack.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_ack  output  1  one-cycle fetch completion pulse.
REQ-007 d_req  input  1  data request, held high until d_ack.
REQ-008 d_we  input  1  1 = store, 0 = load.
REQ-009 d_addr  input  32  data byte address.
REQ-010 d_wdata  input  32  store data.
REQ-011 d_be  input  4  store/load byte lanes.
REQ-012 d_ack  output  1  one-cycle data completion pulse.
REQ-013 rdata  output  32  read data, valid while if_ack or d_ack is high.
REQ-014 err  output  1  high with the ack pulse when the transaction was aborted by the watchdog.
REQ-015 stall  output  1  pipeline hold to decoder/datapath.
REQ-016 address  output  32  bus word address.
REQ-017 read  output  1  bus read strobe.
REQ-018 write  output  1  bus write strobe.
REQ-019 writedata  output  32  bus write data.
REQ-020 byteenable  output  4  bus byte lanes.
REQ-021 waitrequest  input  1  slave stall; bus outputs held while high.
REQ-022 readdata  input  32  bus read data, sampled when waitrequest low.

Function
REQ-023 FSM states IDLE, BUS_I, BUS_D, RESP; all bus outputs, rdata, acks and err are registered.
REQ-024 IDLE: d_req high -> BUS_D; else if_req high -> BUS_I; data has fixed priority over fetch when both are high.
REQ-025 On entry to BUS_I: address = {if_addr[31:2],2'b00}, read = 1, byteenable = 4'b1111.
REQ-026 On entry to BUS_D: address = {d_addr[31:2],2'b00}, byteenable = d_be, read = ~d_we, write = d_we, writedata = d_wdata.
REQ-027 read and write are never high in the same cycle.
REQ-028 address, read, write, writedata, byteenable stay constant while waitrequest = 1.
REQ-029 In BUS_x with waitrequest = 0: transaction completes that cycle; read/write deassert next edge; readdata captured into rdata for reads (rdata = 0 for stores); go to RESP.
REQ-030 RESP lasts exactly one cycle: matching ack = 1; then IDLE; no new request is accepted in RESP.
REQ-031 Minimum latency: request high at edge N -> strobe cycle N..N+1 -> ack cycle N+1..N+2 with waitrequest = 0 throughout.
REQ-032 Watchdog counter clears on entry to BUS_x and increments per waitrequest = 1 cycle; on reaching WAIT_LIMIT (non-zero): strobes drop, RESP entered with err = 1, rdata = 0.
REQ-033 d_req with d_be = 4'b0000: no bus cycle issued; IDLE -> RESP directly, d_ack = 1, rdata = 0, err = 0.
REQ-034 Request deasserted before its ack (protocol violation): in-flight bus cycle still completes; ack still pulses.
REQ-035 stall = (if_req | d_req) & ~(if_ack | d_ack), combinational.
REQ-036 err = 0 whenever no ack is high.

Reset
REQ-037 reset low immediately forces state IDLE, read = 0, write = 0, address = 0, writedata = 0, byteenable = 0, rdata = 0, if_ack = 0, d_ack = 0, err = 0, watchdog = 0.
REQ-038 reset asserted mid-transaction abandons it with no ack; stall keeps following REQ-035.
REQ-039 First request is sampled on the first rising edge with reset high.

Verification
REQ-040 Fetch: if_req, if_addr = 0xBFC00003, waitrequest = 0, readdata = 0x24020005 -> address = 0xBFC00000, read = 1 one cycle, byteenable = 4'hF, if_ack next cycle with rdata = 0x24020005.
REQ-041 Contention: if_req and d_req both high, d_we = 1, d_addr = 0x1000, d_wdata = 0xDEADBEEF, d_be = 4'b0011 -> store issued first (write = 1, byteenable = 4'b0011); fetch starts after d_ack.
REQ-042 Wait states: 3 cycles waitrequest = 1 on a load -> bus outputs unchanged for 4 cycles; d_ack 1 cycle after waitrequest falls; stall high throughout until d_ack.
REQ-043 Watchdog: WAIT_LIMIT = 4, waitrequest stuck high -> read drops after 4 wait cycles; d_ack = 1, err = 1, rdata = 0.
REQ-044 d_be = 0 store -> read and write stay 0; d_ack one cycle after request.
REQ-045 Reset low during BUS_I with waitrequest = 1 -> read = 0 immediately, no if_ack; fetch reissued after reset high.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - single-master bus arbiter for MIPS fetch and data ports
module mips_bus_arbiter #(
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        stall,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUS_I = 2'd1,
      BUS_D = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Watchdog is disabled entirely when the limit is zero; otherwise the
   // abort fires on the wait cycle that brings the count up to the limit.
   localparam logic        WD_EN   = (WAIT_LIMIT != 0);
   localparam logic [31:0] WD_LAST = WAIT_LIMIT - 32'd1;

   state_t      state, state_n;
   logic [31:0] wd, wd_n;
   logic [31:0] address_n, writedata_n, rdata_n;
   logic [3:0]  byteenable_n;
   logic        read_n, write_n, if_ack_n, d_ack_n, err_n;

   // Byte offsets are dropped because the bus is word addressed.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

   // Pipeline hold: any pending request not being acknowledged this cycle.
   assign stall = (if_req | d_req) & ~(if_ack | d_ack);

   // State and all registered outputs; reset abandons any in-flight cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         wd         <= 32'd0;
         address    <= 32'd0;
         read       <= 1'b0;
         write      <= 1'b0;
         writedata  <= 32'd0;
         byteenable <= 4'd0;
         rdata      <= 32'd0;
         if_ack     <= 1'b0;
         d_ack      <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         wd         <= wd_n;
         address    <= address_n;
         read       <= read_n;
         write      <= write_n;
         writedata  <= writedata_n;
         byteenable <= byteenable_n;
         rdata      <= rdata_n;
         if_ack     <= if_ack_n;
         d_ack      <= d_ack_n;
         err        <= err_n;
      end
   end

   // Next-state and next-output logic; bus outputs hold unless a transition changes them.
   always_comb begin
      state_n      = state;
      wd_n         = wd;
      address_n    = address;
      read_n       = read;
      write_n      = write;
      writedata_n  = writedata;
      byteenable_n = byteenable;
      rdata_n      = rdata;
      if_ack_n     = 1'b0;
      d_ack_n      = 1'b0;
      err_n        = 1'b0;

      case (state)
         IDLE: begin
            if (d_req) begin
               if (d_be == 4'b0000) begin
                  // Nothing to transfer: acknowledge without touching the bus.
                  state_n = RESP;
                  d_ack_n = 1'b1;
                  rdata_n = 32'd0;
               end else begin
                  state_n      = BUS_D;
                  wd_n         = 32'd0;
                  address_n    = {d_addr[31:2], 2'b00};
                  byteenable_n = d_be;
                  read_n       = ~d_we;
                  write_n      = d_we;
                  writedata_n  = d_wdata;
               end
            end else if (if_req) begin
               state_n      = BUS_I;
               wd_n         = 32'd0;
               address_n    = {if_addr[31:2], 2'b00};
               byteenable_n = 4'b1111;
               read_n       = 1'b1;
               write_n      = 1'b0;
            end
         end

         BUS_I, BUS_D: begin
            if (!waitrequest) begin
               state_n  = RESP;
               read_n   = 1'b0;
               write_n  = 1'b0;
               rdata_n  = read ? readdata : 32'd0;
               if_ack_n = (state == BUS_I);
               d_ack_n  = (state == BUS_D);
            end else if (WD_EN && (wd == WD_LAST)) begin
               state_n  = RESP;
               read_n   = 1'b0;
               write_n  = 1'b0;
               rdata_n  = 32'd0;
               err_n    = 1'b1;
               if_ack_n = (state == BUS_I);
               d_ack_n  = (state == BUS_D);
            end else if (WD_EN) begin
               wd_n = wd + 32'd1;
            end
         end

         RESP: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule
